// File: rtl/ex_mem_pkg.sv
// Shared constants for the EX/MEM stage register: FSM state codes, default
// widths and the packed payload width.
package ex_mem_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] TWO   = 2'b10;

    localparam int N_DEF     = 16;
    localparam int REGW_DEF  = 3;
    localparam int CTRLW_DEF = 4;
    localparam int CNTW_DEF  = 8;

    // Payload layout (MSB first): result, zero, ofl, wr_reg, ctrl
    function automatic int payload_w(input int n, input int regw, input int ctrlw);
        return n + 2 + regw + ctrlw;
    endfunction

    localparam int PAYLOAD_W = N_DEF + 2 + REGW_DEF + CTRLW_DEF;

endpackage

// File: rtl/ex_mem_entry.sv
// One payload slot of the EX/MEM skid buffer: load-enabled register that
// clears to zero under synchronous active-low reset.
module ex_mem_entry
    import ex_mem_pkg::*;
#(
    parameter int W = PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM stage register with a 2-entry skid buffer, flush, and an overflow
// monitor (sticky flag plus saturating count of delivered Ofl results).
//
//   state | meaning
//   EMPTY | no entry held; in_ready=1, out_valid=0
//   ONE   | main holds the oldest entry; skid unused
//   TWO   | main and skid both full; in_ready=0
module ex_mem_skid_reg
    import ex_mem_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int REGW  = REGW_DEF,
    parameter int CTRLW = CTRLW_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_result,
    input  logic             in_zero,
    input  logic             in_ofl,
    input  logic [REGW-1:0]  in_wr_reg,
    input  logic [CTRLW-1:0] in_ctrl,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic             out_zero,
    output logic             out_ofl,
    output logic [REGW-1:0]  out_wr_reg,
    output logic [CTRLW-1:0] out_ctrl,
    input  logic             ofl_clear,
    output logic             ofl_sticky,
    output logic [CNTW-1:0]  ofl_count
);

    localparam int PW = payload_w(N, REGW, CTRLW);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [1:0]      state_q, state_d;
    logic            acc, dlv;
    logic            load_main, load_skid, main_from_skid;
    logic [PW-1:0]   in_payload, main_d, main_q, skid_q;
    logic            ofl_sticky_q;
    logic [CNTW-1:0] ofl_count_q;

    assign in_payload = {in_result, in_zero, in_ofl, in_wr_reg, in_ctrl};
    assign acc        = in_valid & in_ready;
    assign dlv        = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (acc && !dlv) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (acc && dlv) begin
                    load_main = 1'b1;
                end else if (dlv) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (dlv) begin
                    state_d        = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops the incoming result; payload registers keep stale data.
        if (flush) begin
            state_d   = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    always_comb begin
        in_ready  = (state_q != TWO);
        out_valid = (state_q != EMPTY);
    end

    assign main_d = main_from_skid ? skid_q : in_payload;

    ex_mem_entry #(.W(PW)) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_main),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    ex_mem_entry #(.W(PW)) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_skid),
        .d_i    (in_payload),
        .q_o    (skid_q)
    );

    assign {out_result, out_zero, out_ofl, out_wr_reg, out_ctrl} = main_q;

    // A delivered overflow beats a simultaneous clear, restarting the count at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ofl_sticky_q <= 1'b0;
            ofl_count_q  <= '0;
        end else if (dlv && out_ofl) begin
            ofl_sticky_q <= 1'b1;
            if (ofl_clear) begin
                ofl_count_q <= CNTW'(1);
            end else if (ofl_count_q != CNT_MAX) begin
                ofl_count_q <= ofl_count_q + CNTW'(1);
            end
        end else if (ofl_clear) begin
            ofl_sticky_q <= 1'b0;
            ofl_count_q  <= '0;
        end
    end

    assign ofl_sticky = ofl_sticky_q;
    assign ofl_count  = ofl_count_q;

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Execute-to-memory stage register that captures the ALU's 16-bit result, Zero and Ofl flags, together with the destination register index and memory/writeback control bits.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the execute stage never loses a result when the memory stage stalls.
- Provides a pipeline flush and a sticky/counting overflow monitor for the exception logic.
- Sits directly downstream of the ALU and directly upstream of the data-memory stage.

Parameters:
- N, 16, datapath width of the result.
- REGW, 3, width of the destination register index.
- CTRLW, 4, width of the pass-through memory/writeback control bundle.
- CNTW, 8, width of the saturating overflow event counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  execute stage presents a result this cycle.
- in_ready  out  1  stage can accept a result this cycle.
- in_result  in  N  ALU Out.
- in_zero  in  1  ALU Zero.
- in_ofl  in  1  ALU Ofl.
- in_wr_reg  in  REGW  destination register index.
- in_ctrl  in  CTRLW  memory/writeback control bits.
- flush  in  1  discard all buffered entries.
- out_valid  out  1  oldest entry is valid.
- out_ready  in  1  memory stage consumes the entry this cycle.
- out_result  out  N  payload of the oldest entry.
- out_zero  out  1  payload of the oldest entry.
- out_ofl  out  1  payload of the oldest entry.
- out_wr_reg  out  REGW  payload of the oldest entry.
- out_ctrl  out  CTRLW  payload of the oldest entry.
- ofl_clear  in  1  clears ofl_sticky and ofl_count.
- ofl_sticky  out  1  an overflowing result has been delivered since the last clear.
- ofl_count  out  CNTW  number of overflowing results delivered, saturating.

Behaviour:
- Definitions:
  - acc = in_valid & in_ready.
  - dlv = out_valid & out_ready.
- Storage:
  - Two entries, main and skid.
  - All out_* ports are driven directly from main registers; there is no combinational path from inputs to outputs.
- State machine:
  - States: EMPTY, ONE, TWO.
  - in_ready = (state != TWO), decoded from the state register only; it never depends on out_ready.
  - out_valid = (state != EMPTY).
- Transitions (flush = 0):
  - EMPTY: acc -> ONE, main <= in.
  - ONE: acc & ~dlv -> TWO, skid <= in.
  - ONE: acc & dlv -> ONE, main <= in.
  - ONE: ~acc & dlv -> EMPTY.
  - ONE: otherwise hold.
  - TWO: dlv -> ONE, main <= skid.
  - TWO: otherwise hold; in_valid is ignored.
- Latency and ordering:
  - A result accepted at edge k appears on out_* after edge k when it becomes oldest.
  - Strict FIFO order is preserved.
  - Sustained throughput is 1 per cycle while out_ready = 1.
- Flush:
  - flush = 1 at an edge -> state <= EMPTY.
  - Flush has priority over a simultaneous acc and dlv; the input in that cycle is dropped.
  - The delivery in that cycle still counts as delivered for the ofl monitor (the consumer saw it).
  - Payload registers keep their values.
- Reset (rst_n = 0 at an edge), overriding flush and everything else:
  - State EMPTY, so out_valid = 0 and in_ready = 1.
  - All payload registers 0.
  - ofl_sticky 0, ofl_count 0.
  - Reset mid-transfer discards both entries without completing any handshake.
- Overflow monitor:
  - On dlv & out_ofl: ofl_sticky <= 1; ofl_count <= ofl_count + 1, saturating at 2^CNTW - 1.
  - ofl_clear resets both to 0.
  - A simultaneous dlv & out_ofl with ofl_clear -> ofl_sticky = 1, ofl_count = 1 (the set wins over the clear).
- Data width: payloads are stored verbatim; no arithmetic on the result.

Decomposition:
- Package ex_mem_pkg holds:
  - state localparams EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b10;
  - default widths N, REGW, CTRLW, CNTW;
  - the packed payload width N + 2 + REGW + CTRLW.
- One sub-module, ex_mem_entry:
  - a payload register with synchronous active-low reset to 0 and a load enable;
  - instantiated twice, as main and skid.
- The FSM and the overflow monitor live in the top module.

Test Plan:
- Reset: rst_n = 0 for 2 cycles while in_valid = 1 -> out_valid = 0, in_ready = 1, out_result = 0x0000, ofl_sticky = 0, ofl_count = 0.
- Single pass: in_result = 0x1234, in_wr_reg = 5, in_valid = 1 for one cycle, out_ready = 1 -> next cycle out_valid = 1 with out_result = 0x1234 and out_wr_reg = 5; the cycle after, out_valid = 0.
- Backpressure: out_ready = 0, push 0xAAAA then 0xBBBB -> in_ready = 0 after the second edge, and a 0xCCCC offered while in_ready = 0 is not taken. Then out_ready = 1 -> delivers 0xAAAA, then 0xBBBB, in_ready rises one cycle after the first delivery, and nothing is lost or reordered.
- Streaming: 8 back-to-back results 0x0001..0x0008 with out_ready = 1 -> delivered in order, one per cycle, in_ready constantly 1.
- Flush: in state TWO, assert flush with in_valid = 1 and in_result = 0xDEAD -> next cycle out_valid = 0, in_ready = 1, and 0xDEAD never appears.
- Ofl monitor:
  - Deliver an entry with in_ofl = 1 while ofl_clear = 1 in the same cycle -> ofl_sticky = 1, ofl_count = 1.
  - Deliver 300 ofl entries -> ofl_count = 255.
  - Pulse ofl_clear alone -> ofl_sticky = 0, ofl_count = 0.
